// File: rtl/pixel_window_source.sv
`default_nettype none
// ============================================================================
// Module   : pixel_window_source
// Brief    : Turns a serial line of RGB pixels into one centred horizontal
//            WINDOW-pixel window per pixel, with border fill at line ends.
//            Define WINDOW_ZERO_BORDER_EN for zero fill instead of replication.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_window_source #(
    parameter int PIXEL_WIDTH = 24,
    parameter int WINDOW      = 5,
    parameter int LINE_WIDTH  = 640
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [PIXEL_WIDTH-1:0]        in_pixel,
    input  logic                          in_valid,
    input  logic                          in_sol,
    output logic                          in_ready,
    output logic [WINDOW*PIXEL_WIDTH-1:0] out_window,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sol,
    output logic                          out_eol,
    output logic                          sol_error
);

    localparam int c_col_w  = $clog2(LINE_WIDTH);
    localparam int c_fcnt_w = $clog2(WINDOW / 2 + 1);

    localparam logic [c_col_w-1:0]  c_last   = c_col_w'(LINE_WIDTH - 1);
    localparam logic [c_col_w-1:0]  c_half   = c_col_w'(WINDOW / 2);
    localparam logic [c_fcnt_w-1:0] c_half_f = c_fcnt_w'(WINDOW / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // r_hist[WINDOW-1] is the newest pixel; the window is the history itself
    logic [PIXEL_WIDTH-1:0]  r_hist [WINDOW];
    logic [c_col_w-1:0]      r_col;
    logic [c_fcnt_w-1:0]     r_fcnt;
    logic                    r_out_valid;
    logic                    r_out_sol;
    logic                    r_out_eol;
    logic                    r_sol_error;

    logic                    w_rdy_state;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_take;
    logic [c_col_w-1:0]      w_col_inc;
    logic [c_fcnt_w-1:0]     w_fcnt_inc;
    logic [PIXEL_WIDTH-1:0]  w_head_fill;
    logic [PIXEL_WIDTH-1:0]  w_tail_fill;

`ifdef WINDOW_ZERO_BORDER_EN
    assign w_head_fill = '0;
    assign w_tail_fill = '0;
`else
    assign w_head_fill = in_pixel;
    assign w_tail_fill = r_hist[WINDOW-1];
`endif

    assign w_col_inc  = r_col + 1'b1;
    assign w_fcnt_inc = r_fcnt + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy_state = 1'b0;
        case (r_state)
            S_IDLE:  w_rdy_state = 1'b1;
            S_FILL:  w_rdy_state = 1'b1;
            S_RUN:   w_rdy_state = !r_out_valid || out_ready;
            default: w_rdy_state = 1'b0;
        endcase

        w_in_ready = reset_n && w_rdy_state;
        w_accept   = in_valid && w_in_ready;
        w_take     = r_out_valid && out_ready;

        // A start-of-line pixel always begins a fresh line, wherever it lands
        if (w_accept && in_sol) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept && (w_col_inc == c_half)) begin
                        w_state_nxt = (c_half == c_last) ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && (w_col_inc == c_last)) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_take && (r_fcnt == c_half_f)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < WINDOW; k++) begin
                r_hist[k] <= '0;
            end
            r_col       <= '0;
            r_fcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_sol   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_sol_error <= 1'b0;
        end else begin
            r_sol_error <= 1'b0;
            if (w_accept && in_sol) begin
                // Pre-load the columns left of column 0 with the border value
                for (int k = 0; k < WINDOW - 1; k++) begin
                    r_hist[k] <= w_head_fill;
                end
                r_hist[WINDOW-1] <= in_pixel;
                r_col            <= '0;
                r_fcnt           <= '0;
                r_out_valid      <= 1'b0;
                r_out_sol        <= 1'b0;
                r_out_eol        <= 1'b0;
                r_sol_error      <= (r_state != S_IDLE);
            end else if (w_accept && (r_state != S_IDLE)) begin
                for (int k = 0; k < WINDOW - 1; k++) begin
                    r_hist[k] <= r_hist[k+1];
                end
                r_hist[WINDOW-1] <= in_pixel;
                r_col            <= w_col_inc;
                r_out_valid      <= (r_state == S_RUN) || (w_col_inc == c_half);
                r_out_sol        <= (r_state == S_FILL) && (w_col_inc == c_half);
                r_out_eol        <= 1'b0;
            end else if (w_take) begin
                if ((r_state == S_FLUSH) && (r_fcnt != c_half_f)) begin
                    // Past the last column: shift border pixels in from the right
                    for (int k = 0; k < WINDOW - 1; k++) begin
                        r_hist[k] <= r_hist[k+1];
                    end
                    r_hist[WINDOW-1] <= w_tail_fill;
                    r_fcnt           <= w_fcnt_inc;
                    r_out_sol        <= 1'b0;
                    r_out_eol        <= (w_fcnt_inc == c_half_f);
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_sol   <= 1'b0;
                    r_out_eol   <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < WINDOW; g++) begin : g_pack
        assign out_window[g*PIXEL_WIDTH +: PIXEL_WIDTH] = r_hist[g];
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sol   = r_out_sol;
    assign out_eol   = r_out_eol;
    assign sol_error = r_sol_error;

endmodule

`default_nettype wire

// File: tb/tb_pixel_window_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_window_source
// Brief    : Directed, table-driven bench for pixel_window_source (LINE_WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_window_source;

    localparam int c_pw = 24;
    localparam int c_ww = 5 * c_pw;
    localparam int c_n  = 8;

`ifdef WINDOW_ZERO_BORDER_EN
    localparam bit c_zero = 1'b1;
`else
    localparam bit c_zero = 1'b0;
`endif

    typedef logic [c_pw-1:0] line_t [c_n];

    typedef struct {
        logic            vld;
        logic            sol;
        logic [c_pw-1:0] pix;
        logic            ordy;
        logic            e_rdy;
        logic            e_ov;
        logic            e_sol;
        logic            e_eol;
        logic [c_ww-1:0] e_win;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [c_pw-1:0] in_pixel;
    logic            in_valid;
    logic            in_sol;
    logic            in_ready;
    logic [c_ww-1:0] out_window;
    logic            out_valid;
    logic            out_ready;
    logic            out_sol;
    logic            out_eol;
    logic            sol_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [c_pw-1:0] src_pix [$];
    logic            src_sol [$];
    logic [c_ww-1:0] got_win [$];
    logic            got_sol [$];
    logic            got_eol [$];
    int              n_solerr;

    vec_t            tv [12];
    logic [c_ww-1:0] exp1 [c_n];

    always #5 clock = ~clock;

    pixel_window_source #(
        .PIXEL_WIDTH (c_pw),
        .WINDOW      (5),
        .LINE_WIDTH  (c_n)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_sol     (in_sol),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .sol_error  (sol_error)
    );

    function automatic logic [c_ww-1:0] mk(input int a, input int b, input int c,
                                           input int d, input int e);
        return {24'(e), 24'(d), 24'(c), 24'(b), 24'(a)};
    endfunction

    function automatic vec_t mkv(input logic v, input logic s, input int p, input logic r,
                                 input logic er, input logic eo, input logic es,
                                 input logic ee, input logic [c_ww-1:0] w);
        vec_t t;
        t.vld = v; t.sol = s; t.pix = 24'(p); t.ordy = r;
        t.e_rdy = er; t.e_ov = eo; t.e_sol = es; t.e_eol = ee; t.e_win = w;
        return t;
    endfunction

    // Reference: slot k of centre c shows column c-2+k, clamped or zeroed off-line
    function automatic logic [c_ww-1:0] exp_win(input line_t p, input int c);
        logic [c_ww-1:0] w;
        logic [c_pw-1:0] v;
        int              col;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            col = c - 2 + k;
            if (col < 0)            v = c_zero ? 24'h0 : p[0];
            else if (col > c_n - 1) v = c_zero ? 24'h0 : p[c_n-1];
            else                    v = p[col];
            w[k*c_pw +: c_pw] = v;
        end
        return w;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [c_ww-1:0] act,
                          input logic [c_ww-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic v, input logic s,
                        input logic [c_pw-1:0] p, input logic r);
        @(negedge clock);
        reset_n   = rn;
        in_valid  = v;
        in_sol    = s;
        in_pixel  = p;
        out_ready = r;
        #1;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1
    task automatic run_stream(input int mode, input int budget);
        int              idx;
        int              cyc;
        logic            ordy;
        logic            prev_stall;
        logic [c_ww-1:0] prev_w;
        logic            prev_s;
        logic            prev_e;
        bit              done;
        idx = 0; cyc = 0; prev_stall = 1'b0; prev_w = '0; prev_s = 1'b0;
        prev_e = 1'b0; done = 1'b0; n_solerr = 0;
        got_win.delete(); got_sol.delete(); got_eol.delete();
        while (!done && cyc < budget) begin
            ordy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (idx < src_pix.size()) step(1'b1, 1'b1, src_sol[idx], src_pix[idx], ordy);
            else                      step(1'b1, 1'b0, 1'b0, '0, ordy);
            if (prev_stall) begin
                check1("hold_valid", out_valid, 1'b1);
                checkw("hold_window", out_window, prev_w);
                check1("hold_sol", out_sol, prev_s);
                check1("hold_eol", out_eol, prev_e);
            end
            if (out_valid && !ordy) check1("stall_in_ready", in_ready, 1'b0);
            if (sol_error) begin
                n_solerr++;
                check1("sol_error_drops_valid", out_valid, 1'b0);
            end
            if (out_valid && ordy) begin
                got_win.push_back(out_window);
                got_sol.push_back(out_sol);
                got_eol.push_back(out_eol);
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !ordy;
            prev_w = out_window; prev_s = out_sol; prev_e = out_eol;
            if (idx >= src_pix.size() && !out_valid && in_ready) done = 1'b1;
            cyc++;
        end
        check1("stream_completes", done, 1'b1);
    endtask

    task automatic load_line(input int first);
        for (int i = 0; i < c_n; i++) begin
            src_pix.push_back(24'(first + i));
            src_sol.push_back(i == 0);
        end
    endtask

    task automatic compare_exp1(input string tag, input int base);
        checki({tag, "_count"}, got_win.size(), base + c_n);
        for (int i = 0; i < c_n; i++) begin
            if (base + i < got_win.size()) begin
                checkw({tag, "_win"}, got_win[base+i], exp1[i]);
                check1({tag, "_sol"}, got_sol[base+i], i == 0);
                check1({tag, "_eol"}, got_eol[base+i], i == c_n - 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_t oldp;
        line_t newp;

        reset_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_pixel = '0; out_ready = 1'b0;

        exp1[0] = c_zero ? mk(0, 0, 1, 2, 3) : mk(1, 1, 1, 2, 3);
        exp1[1] = c_zero ? mk(0, 1, 2, 3, 4) : mk(1, 1, 2, 3, 4);
        exp1[2] = mk(1, 2, 3, 4, 5);
        exp1[3] = mk(2, 3, 4, 5, 6);
        exp1[4] = mk(3, 4, 5, 6, 7);
        exp1[5] = mk(4, 5, 6, 7, 8);
        exp1[6] = c_zero ? mk(5, 6, 7, 8, 0) : mk(5, 6, 7, 8, 8);
        exp1[7] = c_zero ? mk(6, 7, 8, 0, 0) : mk(6, 7, 8, 8, 8);

        //             vld sol pix ordy | rdy ov sol eol window
        tv[0]  = mkv(1, 1, 1, 1,   1, 0, 0, 0, '0);
        tv[1]  = mkv(1, 0, 2, 1,   1, 0, 0, 0, '0);
        tv[2]  = mkv(1, 0, 3, 1,   1, 0, 0, 0, '0);
        tv[3]  = mkv(1, 0, 4, 1,   1, 1, 1, 0, exp1[0]);
        tv[4]  = mkv(1, 0, 5, 1,   1, 1, 0, 0, exp1[1]);
        tv[5]  = mkv(1, 0, 6, 1,   1, 1, 0, 0, exp1[2]);
        tv[6]  = mkv(1, 0, 7, 1,   1, 1, 0, 0, exp1[3]);
        tv[7]  = mkv(1, 0, 8, 1,   1, 1, 0, 0, exp1[4]);
        tv[8]  = mkv(0, 0, 0, 1,   0, 1, 0, 0, exp1[5]);
        tv[9]  = mkv(0, 0, 0, 1,   0, 1, 0, 0, exp1[6]);
        tv[10] = mkv(0, 0, 0, 1,   0, 1, 0, 1, exp1[7]);
        tv[11] = mkv(0, 0, 0, 1,   1, 0, 0, 0, '0);

        // Reset state
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 24'h5, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);
        checkw("reset_out_window", out_window, '0);
        check1("reset_out_sol", out_sol, 1'b0);
        check1("reset_out_eol", out_eol, 1'b0);
        check1("reset_sol_error", sol_error, 1'b0);
        check1("reset_in_ready", in_ready, 1'b0);

        // Test 1: one line, no backpressure, cycle-exact table
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tv[i].vld, tv[i].sol, tv[i].pix, tv[i].ordy);
            check1($sformatf("t1_in_ready[%0d]", i), in_ready, tv[i].e_rdy);
            check1($sformatf("t1_out_valid[%0d]", i), out_valid, tv[i].e_ov);
            check1($sformatf("t1_out_sol[%0d]", i), out_sol, tv[i].e_sol);
            check1($sformatf("t1_out_eol[%0d]", i), out_eol, tv[i].e_eol);
            check1($sformatf("t1_sol_error[%0d]", i), sol_error, 1'b0);
            if (tv[i].e_ov) checkw($sformatf("t1_window[%0d]", i), out_window, tv[i].e_win);
        end

        // Test 2: same line under out_ready 1,0,0,1
        src_pix.delete(); src_sol.delete();
        load_line(1);
        run_stream(1, 120);
        compare_exp1("t2", 0);
        checki("t2_sol_error_count", n_solerr, 0);

        // Test 3: in_sol with pixel 0xA at column 5 restarts the line
        src_pix.delete(); src_sol.delete();
        for (int i = 0; i < 5; i++) begin
            src_pix.push_back(24'(i + 1));
            src_sol.push_back(i == 0);
        end
        for (int i = 0; i < c_n; i++) begin
            src_pix.push_back(24'(10 + i));
            src_sol.push_back(i == 0);
        end
        for (int i = 0; i < c_n; i++) begin
            oldp[i] = 24'(i + 1);
            newp[i] = 24'(10 + i);
        end
        run_stream(0, 120);
        checki("t3_sol_error_count", n_solerr, 1);
        checki("t3_count", got_win.size(), 3 + c_n);
        for (int i = 0; i < 3 + c_n; i++) begin
            if (i < got_win.size()) begin
                checkw("t3_win", got_win[i], (i < 3) ? exp_win(oldp, i) : exp_win(newp, i - 3));
                check1("t3_sol", got_sol[i], (i == 0) || (i == 3));
                check1("t3_eol", got_eol[i], i == 3 + c_n - 1);
            end
        end

        // Test 4: reset pulse at column 4 abandons the line
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 24'(i + 1), 1'b1);
        step(1'b0, 1'b1, 1'b0, 24'h5, 1'b1);
        check1("t4_in_ready_in_reset", in_ready, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check1("t4_out_valid", out_valid, 1'b0);
        checkw("t4_out_window", out_window, '0);
        check1("t4_out_sol", out_sol, 1'b0);
        check1("t4_out_eol", out_eol, 1'b0);
        check1("t4_sol_error", sol_error, 1'b0);
        check1("t4_idle_ready", in_ready, 1'b1);
        src_pix.delete(); src_sol.delete();
        load_line(1);
        run_stream(0, 60);
        compare_exp1("t4", 0);

        // Test 5: pixels without in_sol in IDLE are discarded
        src_pix.delete(); src_sol.delete();
        src_pix.push_back(24'h55); src_sol.push_back(1'b0);
        src_pix.push_back(24'h66); src_sol.push_back(1'b0);
        src_pix.push_back(24'h77); src_sol.push_back(1'b0);
        load_line(1);
        run_stream(0, 60);
        compare_exp1("t5", 0);
        checki("t5_sol_error_count", n_solerr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
